mvm_arbiter: RTL and testbench
==============================

// Module: mvm_arbiter
// PURPOSE
//  Shares one matrixVectorMultiply engine between NUM_REQ requesters (e.g. vertex transform lanes).
//  Round-robin arbitration, operand latching, start sequencing, result capture and a done watchdog.
//  Sits between the requesters and the engine: drives start/m1/v1 and consumes v_out/done.
// PARAMETERS
//  NUM_REQ  2   number of requesters, 2..8
//  WIDTH    32  element width (Q16.16 when engine FIXED_POINT=1); passed through, no arithmetic here
//  TIMEOUT  64  max cycles waiting for engine done before abort, >= 8
// PORTS
//  clk_in          in   1                      system clock
//  rst_n_in        in   1                      async active-low reset
//  req_in          in   NUM_REQ                request per lane, held until grant
//  m_in            in   [NUM_REQ][4][4][WIDTH] per-lane matrix, stable while req high
//  v_in            in   [NUM_REQ][4][WIDTH]    per-lane vector, stable while req high
//  grant_out       out  NUM_REQ                one-hot 1-cycle pulse: operands latched
//  resp_valid_out  out  NUM_REQ                one-hot 1-cycle pulse: result/err valid for lane
//  resp_err_out    out  1                      qualifies resp_valid: 1 = timeout abort
//  v_out           out  [4][WIDTH]             result vector, held until next response
//  busy_out        out  1                      high in any state but IDLE
//  mvm_start_out   out  1                      engine start pulse
//  mvm_m1_out      out  [4][4][WIDTH]          latched matrix to engine
//  mvm_v1_out      out  [4][WIDTH]             latched vector to engine
//  mvm_v_in        in   [4][WIDTH]             engine result
//  mvm_done_in     in   1                      engine done
//  mvm_rst_out     out  1                      engine reset, active-high
// BEHAVIOUR
//  Reset (rst_n_in low, async): state IDLE, rr pointer=0, owner=0, all pulses 0, v_out=0,
//   mvm_m1_out/mvm_v1_out=0, resp_err_out=0; mvm_rst_out=1 while rst_n_in low (comb OR with ABORT).
//  FSM: IDLE -> ISSUE -> WAIT -> RESP|ABORT -> IDLE.
//  IDLE: if |req_in: winner = first set req scanning ptr, ptr+1.. mod NUM_REQ; latch m_in/v_in[winner]
//   into mvm_* regs, owner=winner, grant_out[winner]=1 this cycle, ptr=(winner+1)%NUM_REQ -> ISSUE.
//  ISSUE: mvm_start_out=1 exactly one cycle; timer=0 -> WAIT.
//  WAIT: mvm_done_in sampled only here. done=1: v_out<=mvm_v_in -> RESP. Else timer++;
//   timer==TIMEOUT-1 -> ABORT.
//  RESP: resp_valid_out[owner]=1, resp_err_out=0 -> IDLE.
//  ABORT: mvm_rst_out=1, resp_valid_out[owner]=1, resp_err_out=1, v_out<=0 -> IDLE.
//  Latency grant->resp_valid = engine latency + 3 cycles (5-cycle engine: 8). Single op in flight.
//  Requester drops req the cycle after grant, or keeps it high to re-queue; re-arb only in IDLE.
//  req deasserted before grant: no grant, no side effect. Simultaneous reqs: rr order, no starvation.
//  mvm_m1_out/mvm_v1_out constant from grant to next grant; m_in changes post-grant ignored.
//  Spurious mvm_done_in outside WAIT ignored. resp_err_out=0 whenever resp_valid_out is 0.
//  Reset mid-operation: op dropped, no response issued, engine held reset.
// TESTING
//  1 Lane0 req, m={{-1,2,3,4},{5,6.5,7.75,8},{9,10,-26.25,12},{13,14.125,15,16}}, v={-3.5,6.5,7.75,12}
//    -> grant_out=01, start 1 cycle later, resp_valid_out=01 after 8 cycles, err=0,
//    v_out={87.75,180.8125,-25.9375,354.5625}.
//  2 Both lanes req same cycle after reset -> grant order 0,1,0,1 while held; each resp to matching lane.
//  3 Lane1 req alone, then lanes 0+1 -> ptr wraps: lane0 granted next (ptr=0 after lane1).
//  4 Engine done tied low -> resp_valid to owner, err=1, mvm_rst_out 1-cycle pulse, v_out=0,
//    TIMEOUT+2 cycles after grant; next req served normally.
//  5 rst_n_in low during WAIT -> all outputs reset values immediately, no resp_valid; after release,
//    new req completes normally.
//  6 Change m_in/v_in the cycle after grant -> mvm_* unchanged, result matches pre-grant operands.

Source files
------------

// File: rtl/mvm_arbiter.sv
// mvm_arbiter: round-robin front end sharing one matrix-vector engine, with operand latch, start, result capture and done watchdog
module mvm_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                                    clk_in,
   input  logic                                    rst_n_in,
   input  logic [NUM_REQ-1:0]                      req_in,
   input  logic [NUM_REQ-1:0][3:0][3:0][WIDTH-1:0] m_in,
   input  logic [NUM_REQ-1:0][3:0][WIDTH-1:0]      v_in,
   output logic [NUM_REQ-1:0]                      grant_out,
   output logic [NUM_REQ-1:0]                      resp_valid_out,
   output logic                                    resp_err_out,
   output logic [3:0][WIDTH-1:0]                   v_out,
   output logic                                    busy_out,
   output logic                                    mvm_start_out,
   output logic [3:0][3:0][WIDTH-1:0]              mvm_m1_out,
   output logic [3:0][WIDTH-1:0]                   mvm_v1_out,
   input  logic [3:0][WIDTH-1:0]                   mvm_v_in,
   input  logic                                    mvm_done_in,
   output logic                                    mvm_rst_out
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ABORT} state_t;
   state_t                     state_q, state_d;
   logic [IW-1:0]              ptr_q, ptr_d, owner_q, owner_d, win;
   logic [TW-1:0]              timer_q, timer_d;
   logic [3:0][3:0][WIDTH-1:0] m1_q, m1_d;
   logic [3:0][WIDTH-1:0]      v1_q, v1_d, vout_q, vout_d;
   logic                       take;
   // Scan from the highest offset down so the lowest offset from ptr wins.
   always_comb begin
      win = ptr_q;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req_in[IW'((int'(ptr_q) + k) % NUM_REQ)]) win = IW'((int'(ptr_q) + k) % NUM_REQ);
   end
   assign take = rst_n_in && state_q == IDLE && |req_in;
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      timer_d = timer_q;
      m1_d    = m1_q;
      v1_d    = v1_q;
      vout_d  = vout_q;
      case (state_q)
         IDLE: if (take) begin
            owner_d = win;
            ptr_d   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            m1_d    = m_in[win];
            v1_d    = v_in[win];
            state_d = ISSUE;
         end
         ISSUE: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: if (mvm_done_in) begin
            vout_d  = mvm_v_in;
            state_d = RESP;
         end else if (timer_q == TW'(TIMEOUT - 1)) begin
            vout_d  = '0;
            state_d = ABORT;
         end else begin
            timer_d = timer_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         timer_q <= '0;
         m1_q    <= '0;
         v1_q    <= '0;
         vout_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         timer_q <= timer_d;
         m1_q    <= m1_d;
         v1_q    <= v1_d;
         vout_q  <= vout_d;
      end
   end
   assign grant_out      = take ? (NUM_REQ'(1) << win) : '0;
   assign resp_valid_out = (state_q == RESP || state_q == ABORT) ? (NUM_REQ'(1) << owner_q) : '0;
   assign resp_err_out   = state_q == ABORT;
   assign busy_out       = state_q != IDLE;
   assign mvm_start_out  = state_q == ISSUE;
   assign mvm_rst_out    = !rst_n_in || state_q == ABORT;
   assign mvm_m1_out     = m1_q;
   assign mvm_v1_out     = v1_q;
   assign v_out          = vout_q;
   assert property (@(posedge clk_in) disable iff (!rst_n_in) $onehot0(grant_out));
   assert property (@(posedge clk_in) disable iff (!rst_n_in) $onehot0(resp_valid_out));
   assert property (@(posedge clk_in) disable iff (!rst_n_in) resp_err_out |-> |resp_valid_out);
endmodule

// File: tb/tb_mvm_arbiter.sv
// tb_mvm_arbiter: transaction-timeline reference model plus behavioural engine, directed cases then random traffic
module tb_mvm_arbiter;
   localparam int N = 2, W = 32, TO = 16, LAT = 8;
   typedef logic [3:0][3:0][W-1:0] mat_t;
   typedef logic [3:0][W-1:0] vec_t;
   logic                        clk_in = 1'b0, rst_n_in = 1'b0;
   logic [N-1:0]                req_in = '0;
   logic [N-1:0][3:0][3:0][W-1:0] m_in;
   logic [N-1:0][3:0][W-1:0]    v_in;
   logic [N-1:0]                grant_out, resp_valid_out;
   logic                        resp_err_out, busy_out, mvm_start_out, mvm_done_in, mvm_rst_out;
   vec_t                        v_out, mvm_v1_out, mvm_v_in;
   mat_t                        mvm_m1_out;
   mvm_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .req_in(req_in), .m_in(m_in), .v_in(v_in),
      .grant_out(grant_out), .resp_valid_out(resp_valid_out), .resp_err_out(resp_err_out),
      .v_out(v_out), .busy_out(busy_out), .mvm_start_out(mvm_start_out),
      .mvm_m1_out(mvm_m1_out), .mvm_v1_out(mvm_v1_out), .mvm_v_in(mvm_v_in),
      .mvm_done_in(mvm_done_in), .mvm_rst_out(mvm_rst_out));
   always #5 clk_in = ~clk_in;
   int   n_chk = 0, n_err = 0, cyc = 0;
   bit   eng_on = 1, spur_on = 0;
   int   eng_done = -1;
   vec_t eng_res = '0;
   bit   m_busy = 0, m_to = 0;
   int   m_owner = 0, m_g = 0, m_rc = 0, m_ptr = 0;
   mat_t m_snap;
   vec_t v_snap, v_exp = '0;
   int   gq[$];
   int   last_g = -1, last_gl = -1, last_r = -1, last_rl = -1;
   bit   last_err = 0;
   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
      end
   endtask
   function automatic vec_t mvm(input mat_t m, input vec_t v);
      vec_t   r;
      longint acc;
      for (int i = 0; i < 4; i++) begin
         acc = 0;
         for (int j = 0; j < 4; j++) acc += (longint'(signed'(m[i][j])) * longint'(signed'(v[j]))) >>> 16;
         r[i] = acc[W-1:0];
      end
      return r;
   endfunction
   function automatic logic [W-1:0] q(input real r);
      return W'($rtoi(r * 65536.0));
   endfunction
   function automatic int rr_win(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction
   function automatic mat_t rnd_mat();
      mat_t m;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = $urandom;
      return m;
   endfunction
   function automatic vec_t rnd_vec();
      vec_t v;
      for (int i = 0; i < 4; i++) v[i] = $urandom;
      return v;
   endfunction
   // Expected behaviour per cycle from the op timeline: grant g, start g+1, response g+LAT or g+TO+2.
   task automatic sample();
      logic [N-1:0] eg, er;
      logic         es, eb, ee, emr;
      int           w, gl;
      eg = '0;
      er = '0;
      w  = (rst_n_in && !m_busy) ? rr_win(req_in, m_ptr) : -1;
      if (w >= 0) eg[w] = 1'b1;
      es = rst_n_in && m_busy && cyc == m_g + 1;
      eb = rst_n_in && m_busy && cyc > m_g;
      if (rst_n_in && m_busy && cyc == m_rc) begin
         er[m_owner] = 1'b1;
         v_exp = m_to ? '0 : mvm(m_snap, v_snap);
      end
      if (!rst_n_in) v_exp = '0;
      ee  = |er && m_to;
      emr = !rst_n_in || ee;
      chk("grant", grant_out, eg);
      chk("resp_valid", resp_valid_out, er);
      chk("resp_err", resp_err_out, ee);
      chk("start", mvm_start_out, es);
      chk("busy", busy_out, eb);
      chk("mvm_rst", mvm_rst_out, emr);
      chk("v_out", v_out, v_exp);
      if (es || |er) begin
         for (int r = 0; r < 4; r++) chk("mvm_m1", mvm_m1_out[r], m_snap[r]);
         chk("mvm_v1", mvm_v1_out, v_snap);
      end
      gl = -1;
      for (int l = 0; l < N; l++) if (grant_out[l]) gl = l;
      if (gl >= 0) begin
         gq.push_back(gl);
         last_g  = cyc;
         last_gl = gl;
      end
      for (int l = 0; l < N; l++) if (resp_valid_out[l]) begin
         last_r   = cyc;
         last_rl  = l;
         last_err = resp_err_out;
      end
      if (mvm_start_out && eng_on) begin
         eng_res  = mvm(mvm_m1_out, mvm_v1_out);
         eng_done = cyc + LAT - 2;
      end
      if (!rst_n_in) begin
         m_busy   = 0;
         m_ptr    = 0;
         eng_done = -1;
      end else if (|er) m_busy = 0;
      if (w >= 0) begin
         m_busy  = 1;
         m_owner = w;
         m_g     = cyc;
         m_snap  = m_in[w];
         v_snap  = v_in[w];
         m_ptr   = (w + 1) % N;
         m_to    = !eng_on;
         m_rc    = cyc + (eng_on ? LAT : TO + 2);
      end
   endtask
   task automatic step();
      bit wait_win;
      @(negedge clk_in);
      sample();
      @(posedge clk_in);
      #1;
      cyc++;
      wait_win    = m_busy && cyc >= m_g + 2 && cyc < m_rc;
      mvm_done_in = (eng_on && cyc == eng_done) || (spur_on && !wait_win && $urandom_range(3) == 0);
      mvm_v_in    = (cyc == eng_done) ? eng_res : rnd_vec();
   endtask
   task automatic wait_grant(input int lim);
      int n0 = gq.size();
      for (int i = 0; i < lim && gq.size() == n0; i++) step();
      chk("grant_arrived", gq.size() > n0, 1'b1);
   endtask
   task automatic wait_resp(input int lim);
      int r0 = last_r;
      for (int i = 0; i < lim && last_r == r0; i++) step();
      chk("resp_arrived", last_r != r0, 1'b1);
   endtask
   task automatic settle();
      for (int i = 0; i < TO + 20 && (m_busy || busy_out); i++) step();
      step();
   endtask
   task automatic do_reset();
      rst_n_in = 1'b0;
      #1;
      chk("arst_busy", busy_out, 1'b0);
      chk("arst_mvm_rst", mvm_rst_out, 1'b1);
      chk("arst_grant", grant_out, '0);
      chk("arst_resp", {resp_valid_out, resp_err_out, mvm_start_out}, '0);
      chk("arst_v_out", v_out, '0);
      chk("arst_v1", mvm_v1_out, '0);
      for (int r = 0; r < 4; r++) chk("arst_m1", mvm_m1_out[r], '0);
      step();
      step();
      rst_n_in = 1'b1;
   endtask
   function automatic int code();
      int c = 0;
      foreach (gq[i]) c = c * 16 + gq[i];
      return c;
   endfunction
   task automatic rand_phase(input int ncyc);
      spur_on = 1;
      for (int c = 0; c < ncyc; c++) begin
         if (!m_busy) eng_on = $urandom_range(7) != 0;
         for (int l = 0; l < N; l++) begin
            if (last_g == cyc - 1 && last_gl == l) begin
               m_in[l]   = rnd_mat();
               v_in[l]   = rnd_vec();
               req_in[l] = 1'($urandom_range(1));
            end else if (!req_in[l]) begin
               if ($urandom_range(3) == 0) begin
                  m_in[l]   = rnd_mat();
                  v_in[l]   = rnd_vec();
                  req_in[l] = 1'b1;
               end
            end else if ($urandom_range(31) == 0) req_in[l] = 1'b0;
         end
         step();
      end
      req_in  = '0;
      spur_on = 0;
      eng_on  = 1;
      settle();
   endtask
   initial begin
      real  tm[4][4];
      real  tv[4];
      vec_t t1_exp, va;
      mat_t ma;
      int   r0;
      m_in = '0; v_in = '0; mvm_v_in = '0; mvm_done_in = 1'b0;
      for (int i = 0; i < 3; i++) step();
      rst_n_in = 1'b1;
      step();
      // lane 0 fixed-point example
      tm = '{'{-1.0, 2.0, 3.0, 4.0}, '{5.0, 6.5, 7.75, 8.0}, '{9.0, 10.0, -26.25, 12.0}, '{13.0, 14.125, 15.0, 16.0}};
      tv = '{-3.5, 6.5, 7.75, 12.0};
      for (int i = 0; i < 4; i++) begin
         v_in[0][i] = q(tv[i]);
         for (int j = 0; j < 4; j++) m_in[0][i][j] = q(tm[i][j]);
      end
      t1_exp = {q(354.5625), q(-25.9375), q(180.8125), q(87.75)};
      req_in = 2'b01;
      wait_grant(5);
      chk("t1_lane", last_gl, 0);
      req_in = '0;
      wait_resp(20);
      chk("t1_latency", last_r - last_g, LAT);
      chk("t1_resp", {last_rl[3:0], 3'b0, last_err}, 5'b00000);
      chk("t1_v_out", v_out, t1_exp);
      settle();
      // both lanes held through reset release
      gq.delete();
      req_in = 2'b11;
      m_in[1] = rnd_mat();
      v_in[1] = rnd_vec();
      do_reset();
      for (int i = 0; i < 80 && gq.size() < 4; i++) step();
      req_in = '0;
      settle();
      chk("t2_order", code(), 'h0101);
      // pointer wrap after lane 1
      gq.delete();
      req_in = 2'b10;
      wait_grant(5);
      req_in = 2'b11;
      wait_grant(20);
      req_in = '0;
      settle();
      chk("t3_order", code(), 'h10);
      // engine never finishes
      eng_on = 0;
      req_in = 2'b01;
      wait_grant(5);
      req_in = '0;
      wait_resp(TO + 10);
      chk("t4_err", last_err, 1'b1);
      chk("t4_latency", last_r - last_g, TO + 2);
      chk("t4_lane", last_rl, 0);
      chk("t4_v_out", v_out, '0);
      eng_on = 1;
      req_in = 2'b10;
      wait_grant(5);
      req_in = '0;
      wait_resp(20);
      chk("t4_next_err", last_err, 1'b0);
      chk("t4_next_lane", last_rl, 1);
      settle();
      // reset while waiting on the engine
      req_in = 2'b01;
      wait_grant(5);
      req_in = '0;
      for (int i = 0; i < 4; i++) step();
      r0 = last_r;
      do_reset();
      for (int i = 0; i < 12; i++) step();
      chk("t5_no_resp", last_r, r0);
      req_in = 2'b11;
      wait_grant(5);
      chk("t5_ptr_reset", last_gl, 0);
      req_in = '0;
      wait_resp(20);
      chk("t5_resp_err", last_err, 1'b0);
      settle();
      // operands changed right after grant
      ma = rnd_mat();
      va = rnd_vec();
      m_in[0] = ma;
      v_in[0] = va;
      req_in = 2'b01;
      wait_grant(5);
      m_in[0] = rnd_mat();
      v_in[0] = rnd_vec();
      req_in = '0;
      wait_resp(20);
      chk("t6_v_out", v_out, mvm(ma, va));
      for (int r = 0; r < 4; r++) chk("t6_m1", mvm_m1_out[r], ma[r]);
      chk("t6_v1", mvm_v1_out, va);
      settle();
      rand_phase(1500);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
